dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Two-requester arbiter in front of the data-bus interconnect. It shares the single LSU-side dbus port between the core LSU and the MMU page-table walker (PTW).
- Registers each grant and holds it until the addressed peripheral acks or the owner aborts. It forwards only the owner's request and returns the response only to the owner.
- Sits between lsu/mmu and the dbus interconnect; the interconnect sees a single LSU-type master.

Parameters:
- PRIO_FIXED, 0, 0 = round-robin between LSU and PTW; 1 = fixed priority, PTW wins.
- TIMEOUT_CYCLES, 256, cycles an owner may wait for ack before forced release (only with the optional feature; must be ≥2).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-high (1 = reset)
- lsu2arb_i  input  $bits(type_lsu2dbus_s)  LSU request (addr, w_data, st_ops, ld_req, st_req)
- arb2lsu_o  output  $bits(type_dbus2lsu_s)  response to LSU (r_data, ack)
- ptw2arb_i  input  $bits(type_lsu2dbus_s)  PTW request, same type; PTW issues loads only
- arb2ptw_o  output  $bits(type_dbus2lsu_s)  response to PTW
- arb2dbus_o  output  $bits(type_lsu2dbus_s)  arbitrated request to interconnect
- dbus2arb_i  input  $bits(type_dbus2lsu_s)  response from interconnect
- lsu_gnt_o  output  1  LSU currently owns the bus
- ptw_gnt_o  output  1  PTW currently owns the bus
- timeout_o  output  1  one-cycle pulse on forced release (tied 0 without the feature)

Behaviour:
- Request valid = ld_req | st_req. Requesters hold the request stable until they see ack, or until they drop it (abort).
- FSM states: IDLE, GNT_LSU, GNT_PTW. Reset state is IDLE. last_owner flop resets to PTW, so LSU wins the first tie.
- In IDLE, no request is forwarded and arb2dbus_o = '0. Next state:
  - Only one requester valid: go to that requester's grant state.
  - Both valid and PRIO_FIXED = 1: GNT_PTW.
  - Both valid and PRIO_FIXED = 0: grant the requester that is not last_owner.
- In GNT_x:
  - arb2dbus_o = x's request, combinational pass-through.
  - arb2x_o = dbus2arb_i.
  - The other requester's response = '0 (ack = 0, r_data = 0).
- Leave GNT_x for IDLE on any of: dbus2arb_i.ack = 1, x drops its request (abort), or timeout. last_owner is updated to x on exit.
- Latency: a request in IDLE at cycle N is forwarded at N+1. A single-cycle-ack peripheral therefore returns ack at N+1 at the earliest. After each ack there is one mandatory IDLE cycle, so back-to-back transactions have a period of 2 cycles minimum.
- Abort and ack in the same cycle: treated as ack. The response is delivered and the FSM goes to IDLE.
- Ack while in IDLE (spurious): ignored and not forwarded to either requester.
- Reset asserted mid-transaction: asynchronously forces IDLE. All outputs go to '0, grants 0, timeout_o 0, counter 0.
- Reset value of every output: arb2lsu_o, arb2ptw_o and arb2dbus_o = '0; lsu_gnt_o, ptw_gnt_o and timeout_o = 0.
- lsu_gnt_o / ptw_gnt_o are registered and are one-hot or zero; they are never both 1.

Optional Feature:
- DBUS_ARB_TIMEOUT_EN
- Defined:
  - An 8..16-bit wait counter is cleared on entering GNT_x and increments each cycle the owner is granted with no ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack, the arbiter returns a synthetic response (ack = 1, r_data = 0) to the owner for that cycle.
  - In the same cycle it pulses timeout_o, deasserts arb2dbus_o (ld_req = st_req = 0), and goes to IDLE next cycle.
- Undefined: no counter is present; timeout_o is tied 0; a missing ack stalls the owner indefinitely.

Decomposition:
- Shared package/defines: the existing type_lsu2dbus_s and type_dbus2lsu_s; a new enum type_dbus_arb_states_e {DBUS_ARB_IDLE, DBUS_ARB_GNT_LSU, DBUS_ARB_GNT_PTW}; a DBUS_ARB_TIMEOUT_W constant.
- Single module; no sub-module is warranted. The timeout counter is an always_ff inside the `ifdef.

Test Plan:
- LSU lw at 0x8000_0010 alone, peripheral acks 1 cycle after forwarding:
  - arb2dbus_o.addr = 0x8000_0010 at N+1.
  - arb2lsu_o.ack = 1 with r_data = 0xDEAD_BEEF at N+1.
  - lsu_gnt_o high for exactly 1 cycle.
  - arb2ptw_o = 0 throughout.
- LSU and PTW both request at reset release with PRIO_FIXED = 0:
  - grant order is LSU, then PTW, then LSU, repeating.
  - each ack is routed to its owner only, with 2-cycle spacing.
- Same contention with PRIO_FIXED = 1 and PTW holding its request asserted: PTW is granted every transaction and LSU is starved (documented behaviour).
- LSU sb in GNT_LSU drops its request before ack (flush): FSM goes to IDLE next cycle, arb2dbus_o = 0, and a pending PTW request is granted the cycle after.
- rst_n pulsed high while in GNT_PTW with no ack: all outputs '0 within the same cycle (asynchronous); first grant after release follows the tie rule (LSU wins).
- DBUS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and an unmapped address (never acks): at the 4th granted cycle, timeout_o = 1 and arb2lsu_o.ack = 1 with r_data = 0; IDLE the next cycle. Without the macro, the LSU stays granted after 100 cycles.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// Shared dbus request/response types and arbiter state encoding.
package dbus_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [1:0]  st_ops;
        logic        ld_req;
        logic        st_req;
    } type_lsu2dbus_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_dbus2lsu_s;

    typedef enum logic [1:0] {
        DBUS_ARB_IDLE,
        DBUS_ARB_GNT_LSU,
        DBUS_ARB_GNT_PTW
    } type_dbus_arb_states_e;

    localparam int unsigned DBUS_ARB_TIMEOUT_W = 16;

    function automatic logic dbus_req_valid(input type_lsu2dbus_s req);
        return req.ld_req | req.st_req;
    endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of the arbiter's requester, interconnect and status signals.
interface dbus_arbiter_if;
    import dbus_arbiter_pkg::*;

    type_lsu2dbus_s lsu2arb_i;
    type_dbus2lsu_s arb2lsu_o;
    type_lsu2dbus_s ptw2arb_i;
    type_dbus2lsu_s arb2ptw_o;
    type_lsu2dbus_s arb2dbus_o;
    type_dbus2lsu_s dbus2arb_i;
    logic           lsu_gnt_o;
    logic           ptw_gnt_o;
    logic           timeout_o;

    // Arbiter side.
    modport slave (
        input  lsu2arb_i,
        input  ptw2arb_i,
        input  dbus2arb_i,
        output arb2lsu_o,
        output arb2ptw_o,
        output arb2dbus_o,
        output lsu_gnt_o,
        output ptw_gnt_o,
        output timeout_o
    );

    // Requester / interconnect side.
    modport master (
        output lsu2arb_i,
        output ptw2arb_i,
        output dbus2arb_i,
        input  arb2lsu_o,
        input  arb2ptw_o,
        input  arb2dbus_o,
        input  lsu_gnt_o,
        input  ptw_gnt_o,
        input  timeout_o
    );

endinterface

// File: rtl/dbus_arbiter.sv
// LSU/PTW arbiter for the shared dbus port; holds each grant until ack or abort.
// Optional wait timeout with forced release: define DBUS_ARB_TIMEOUT_EN.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_FIXED     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    dbus_arbiter_if.slave bus
);

    type_dbus_arb_states_e r_state;
    type_dbus_arb_states_e w_state_d;
    logic                  r_last_ptw;
    logic                  w_last_ptw_d;
    logic                  w_lsu_v;
    logic                  w_ptw_v;
    logic                  w_ack;
    logic                  w_timeout;
    type_dbus2lsu_s        w_owner_rsp;
    type_lsu2dbus_s        w_arb2dbus;
    type_dbus2lsu_s        w_arb2lsu;
    type_dbus2lsu_s        w_arb2ptw;

    assign w_lsu_v = dbus_req_valid(bus.lsu2arb_i);
    assign w_ptw_v = dbus_req_valid(bus.ptw2arb_i);
    assign w_ack   = bus.dbus2arb_i.ack;

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam logic [DBUS_ARB_TIMEOUT_W-1:0] TO_LAST =
        DBUS_ARB_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [DBUS_ARB_TIMEOUT_W-1:0] r_wait_cnt;

    // Cleared in IDLE so every new grant starts counting from zero.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == DBUS_ARB_IDLE) begin
            r_wait_cnt <= '0;
        end else if (!w_ack) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != DBUS_ARB_IDLE) && !w_ack && (r_wait_cnt == TO_LAST);
`else
    logic w_unused_timeout_cycles;
    assign w_unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign w_timeout               = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= DBUS_ARB_IDLE;
            r_last_ptw <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_last_ptw <= w_last_ptw_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_last_ptw_d = r_last_ptw;
        w_arb2dbus   = '0;
        w_arb2lsu    = '0;
        w_arb2ptw    = '0;
        w_owner_rsp  = bus.dbus2arb_i;
        if (w_timeout) begin
            w_owner_rsp.r_data = '0;
            w_owner_rsp.ack    = 1'b1;
        end

        unique case (r_state)
            DBUS_ARB_IDLE: begin
                if (w_lsu_v && w_ptw_v) begin
                    w_state_d = ((PRIO_FIXED != 0) || !r_last_ptw) ? DBUS_ARB_GNT_PTW
                                                                  : DBUS_ARB_GNT_LSU;
                end else if (w_lsu_v) begin
                    w_state_d = DBUS_ARB_GNT_LSU;
                end else if (w_ptw_v) begin
                    w_state_d = DBUS_ARB_GNT_PTW;
                end
            end
            DBUS_ARB_GNT_LSU: begin
                w_arb2dbus = bus.lsu2arb_i;
                w_arb2lsu  = w_owner_rsp;
                if (w_ack || !w_lsu_v || w_timeout) begin
                    w_state_d    = DBUS_ARB_IDLE;
                    w_last_ptw_d = 1'b0;
                end
            end
            DBUS_ARB_GNT_PTW: begin
                w_arb2dbus = bus.ptw2arb_i;
                w_arb2ptw  = w_owner_rsp;
                if (w_ack || !w_ptw_v || w_timeout) begin
                    w_state_d    = DBUS_ARB_IDLE;
                    w_last_ptw_d = 1'b1;
                end
            end
            default: w_state_d = DBUS_ARB_IDLE;
        endcase

        // A forced release withdraws the request from the interconnect.
        if (w_timeout) begin
            w_arb2dbus.ld_req = 1'b0;
            w_arb2dbus.st_req = 1'b0;
        end
    end

    assign bus.arb2dbus_o = w_arb2dbus;
    assign bus.arb2lsu_o  = w_arb2lsu;
    assign bus.arb2ptw_o  = w_arb2ptw;
    assign bus.lsu_gnt_o  = (r_state == DBUS_ARB_GNT_LSU);
    assign bus.ptw_gnt_o  = (r_state == DBUS_ARB_GNT_PTW);
    assign bus.timeout_o  = w_timeout;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench: round-robin and fixed-priority arbiters driven in parallel.
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    localparam int TO   = 4;
    localparam int NONE = 0;
    localparam int LSU  = 1;
    localparam int PTW  = 2;

    typedef struct packed {
        type_lsu2dbus_s dbus;
        type_dbus2lsu_s lsu;
        type_dbus2lsu_s ptw;
        logic           lg;
        logic           pg;
        logic           to;
    } obs_t;

    typedef struct {
        logic        lv;
        logic        pv;
        logic        ack;
        logic [31:0] rdata;
        logic        e_lg;
        logic        e_pg;
        logic        e_lack;
        logic        e_pack;
        logic        e_fx_pg;
        logic [31:0] e_lrdata;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    type_lsu2dbus_s lsu_req;
    type_lsu2dbus_s ptw_req;
    type_dbus2lsu_s dbus_rsp;

    dbus_arbiter_if if_rr ();
    dbus_arbiter_if if_fx ();

    assign if_rr.lsu2arb_i  = lsu_req;
    assign if_rr.ptw2arb_i  = ptw_req;
    assign if_rr.dbus2arb_i = dbus_rsp;
    assign if_fx.lsu2arb_i  = lsu_req;
    assign if_fx.ptw2arb_i  = ptw_req;
    assign if_fx.dbus2arb_i = dbus_rsp;

    dbus_arbiter #(.PRIO_FIXED(0), .TIMEOUT_CYCLES(TO)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_rr)
    );

    dbus_arbiter #(.PRIO_FIXED(1), .TIMEOUT_CYCLES(TO)) u_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_fx)
    );

    obs_t obs [2];
    assign obs[0] = {if_rr.arb2dbus_o, if_rr.arb2lsu_o, if_rr.arb2ptw_o,
                     if_rr.lsu_gnt_o, if_rr.ptw_gnt_o, if_rr.timeout_o};
    assign obs[1] = {if_fx.arb2dbus_o, if_fx.arb2lsu_o, if_fx.arb2ptw_o,
                     if_fx.lsu_gnt_o, if_fx.ptw_gnt_o, if_fx.timeout_o};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, who owned it last, cycles spent waiting.
    int   m_owner    [2];
    logic m_last_ptw [2];
    int   m_wait     [2];
    int   m_next     [2];
    obs_t m_exp      [2];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d]    = NONE;
            m_last_ptw[d] = 1'b1;
            m_wait[d]     = 0;
        end
    endtask

    task automatic model_eval(input int d);
        obs_t           e;
        int             nxt;
        type_lsu2dbus_s req;
        type_dbus2lsu_s rsp;
        logic           lv;
        logic           pv;
        logic           owner_v;
        logic           to;
        e   = '0;
        nxt = m_owner[d];
        lv  = lsu_req.ld_req | lsu_req.st_req;
        pv  = ptw_req.ld_req | ptw_req.st_req;
        if (m_owner[d] == NONE) begin
            if (lv && pv) nxt = (d == 1) ? PTW : (m_last_ptw[d] ? LSU : PTW);
            else if (lv)  nxt = LSU;
            else if (pv)  nxt = PTW;
        end else begin
            req     = (m_owner[d] == LSU) ? lsu_req : ptw_req;
            owner_v = req.ld_req | req.st_req;
            rsp     = dbus_rsp;
            to      = 1'b0;
`ifdef DBUS_ARB_TIMEOUT_EN
            to = !dbus_rsp.ack && (m_wait[d] + 1 == TO);
`endif
            if (to) begin
                req.ld_req  = 1'b0;
                req.st_req  = 1'b0;
                rsp.ack     = 1'b1;
                rsp.r_data  = '0;
            end
            e.dbus = req;
            e.to   = to;
            if (m_owner[d] == LSU) begin
                e.lsu = rsp;
                e.lg  = 1'b1;
            end else begin
                e.ptw = rsp;
                e.pg  = 1'b1;
            end
            if (dbus_rsp.ack || !owner_v || to) nxt = NONE;
        end
        m_exp[d]  = e;
        m_next[d] = nxt;
    endtask

    task automatic model_commit();
        for (int d = 0; d < 2; d++) begin
            if (m_owner[d] != NONE && m_next[d] == NONE) m_last_ptw[d] = (m_owner[d] == PTW);
            m_wait[d]  = (m_owner[d] != NONE && m_next[d] == m_owner[d]) ? m_wait[d] + 1 : 0;
            m_owner[d] = m_next[d];
        end
    endtask

    task automatic settle();
        #1;
        for (int d = 0; d < 2; d++) begin
            model_eval(d);
            chk_obs((d == 0) ? "model/rr" : "model/fx", obs[d], m_exp[d]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    function automatic type_lsu2dbus_s mk_ld(input logic v, input logic [31:0] addr);
        type_lsu2dbus_s r;
        r        = '0;
        r.addr   = addr;
        r.ld_req = v;
        return r;
    endfunction

    vec_t vt [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        type_lsu2dbus_s r;
        lsu_req  = '0;
        ptw_req  = '0;
        dbus_rsp = '0;
        model_reset();

        //         lv    pv    ack   rdata          lg pg la pa fxpg lrdata
        vt[0] = '{1'b1, 1'b1, 1'b1, 32'h1111_1111, 0, 0, 0, 0, 0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'h2222_2222, 1, 0, 1, 0, 1, 32'h2222_2222};
        vt[2] = '{1'b1, 1'b1, 1'b1, 32'h3333_3333, 0, 0, 0, 0, 0, 32'h0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 32'h4444_4444, 0, 1, 0, 1, 1, 32'h0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h5555_5555, 0, 0, 0, 0, 0, 32'h0};
        vt[5] = '{1'b1, 1'b1, 1'b1, 32'h6666_6666, 1, 0, 1, 0, 1, 32'h6666_6666};
        vt[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         0, 0, 0, 0, 0, 32'h0};
        vt[7] = '{1'b1, 1'b0, 1'b0, 32'h0,         0, 0, 0, 0, 0, 32'h0};
        vt[8] = '{1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, 0, 1, 0, 0, 32'hDEAD_BEEF};
        vt[9] = '{1'b0, 1'b0, 1'b0, 32'h0,         0, 0, 0, 0, 0, 32'h0};

        repeat (2) @(negedge clk);
        #1;
        chk_obs("reset/rr", obs[0], '0);
        chk_obs("reset/fx", obs[1], '0);
        rst_n = 1'b0;
        @(negedge clk);

        // Contention from reset release, then a lone LSU load.
        for (int i = 0; i < 10; i++) begin
            lsu_req         = mk_ld(vt[i].lv, 32'h8000_0010);
            ptw_req         = mk_ld(vt[i].pv, 32'h8000_1000);
            dbus_rsp.ack    = vt[i].ack;
            dbus_rsp.r_data = vt[i].rdata;
            settle();
            chk1($sformatf("vec%0d lsu_gnt", i), obs[0].lg, vt[i].e_lg);
            chk1($sformatf("vec%0d ptw_gnt", i), obs[0].pg, vt[i].e_pg);
            chk1($sformatf("vec%0d lsu_ack", i), obs[0].lsu.ack, vt[i].e_lack);
            chk1($sformatf("vec%0d ptw_ack", i), obs[0].ptw.ack, vt[i].e_pack);
            chk32($sformatf("vec%0d lsu_rdata", i), obs[0].lsu.r_data, vt[i].e_lrdata);
            chk1($sformatf("vec%0d fx ptw_gnt", i), obs[1].pg, vt[i].e_fx_pg);
            if (vt[i].e_lg) chk32($sformatf("vec%0d fwd addr", i), obs[0].dbus.addr, 32'h8000_0010);
            advance();
        end

        // LSU store aborted before ack while PTW waits.
        r        = '0;
        r.addr   = 32'h8000_0020;
        r.w_data = 32'h0000_00A5;
        r.st_ops = 2'd2;
        r.st_req = 1'b1;
        lsu_req  = r;
        ptw_req  = '0;
        dbus_rsp = '0;
        settle();
        chk1("abort idle lsu_gnt", obs[0].lg, 1'b0);
        advance();
        ptw_req = mk_ld(1'b1, 32'h8000_1000);
        settle();
        chk1("abort rr lsu_gnt", obs[0].lg, 1'b1);
        chk1("abort fx lsu_gnt", obs[1].lg, 1'b1);
        chk1("abort st fwd", obs[0].dbus.st_req, 1'b1);
        advance();
        lsu_req = '0;
        settle();
        chk1("abort drop lsu_gnt", obs[0].lg, 1'b1);
        advance();
        settle();
        chk32("abort idle dbus st_req", 32'(obs[0].dbus.st_req | obs[0].dbus.ld_req), 32'h0);
        chk32("abort idle dbus addr", obs[0].dbus.addr, 32'h0);
        chk1("abort idle gnt", obs[0].lg | obs[0].pg, 1'b0);
        advance();
        dbus_rsp.ack = 1'b1;
        settle();
        chk1("abort ptw_gnt", obs[0].pg, 1'b1);
        chk1("abort ptw_ack", obs[0].ptw.ack, 1'b1);
        advance();
        ptw_req  = '0;
        dbus_rsp = '0;
        settle();
        advance();

        // Asynchronous reset in the middle of a PTW grant.
        ptw_req = mk_ld(1'b1, 32'h8000_2000);
        settle();
        advance();
        settle();
        chk1("rst pre ptw_gnt", obs[0].pg, 1'b1);
        #2;
        rst_n = 1'b1;
        #1;
        chk_obs("rst async rr", obs[0], '0);
        chk_obs("rst async fx", obs[1], '0);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        lsu_req = mk_ld(1'b1, 32'h8000_0030);
        rst_n   = 1'b0;
        settle();
        chk_obs("rst release idle", obs[0], '0);
        advance();
        dbus_rsp = '{r_data: 32'h1234_5678, ack: 1'b1};
        settle();
        chk1("rst tie rr lsu_gnt", obs[0].lg, 1'b1);
        chk1("rst tie fx ptw_gnt", obs[1].pg, 1'b1);
        advance();
        lsu_req  = '0;
        ptw_req  = '0;
        dbus_rsp = '0;
        settle();
        advance();

        // Unmapped address: nothing ever acks.
        lsu_req = mk_ld(1'b1, 32'hF000_0000);
        settle();
        advance();
`ifdef DBUS_ARB_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            settle();
            chk1($sformatf("to cyc%0d lsu_gnt", k), obs[0].lg, 1'b1);
            chk1($sformatf("to cyc%0d timeout", k), obs[0].to, (k == TO));
            chk1($sformatf("to cyc%0d lsu_ack", k), obs[0].lsu.ack, (k == TO));
            chk32($sformatf("to cyc%0d rdata", k), obs[0].lsu.r_data, 32'h0);
            advance();
        end
        lsu_req = '0;
        settle();
        chk1("to after lsu_gnt", obs[0].lg, 1'b0);
        chk1("to after timeout", obs[0].to, 1'b0);
        advance();
`else
        for (int k = 0; k < 100; k++) begin
            settle();
            advance();
        end
        settle();
        chk1("stall lsu_gnt", obs[0].lg, 1'b1);
        chk1("stall timeout", obs[0].to, 1'b0);
        advance();
        lsu_req = '0;
        settle();
        advance();
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int q = 0; q < 2; q++) begin
                r        = '0;
                r.addr   = $urandom;
                r.w_data = $urandom;
                r.st_ops = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 9) < 6) begin
                    if ($urandom_range(0, 1) == 0) r.ld_req = 1'b1;
                    else                           r.st_req = 1'b1;
                end
                if (q == 0) lsu_req = r;
                else        ptw_req = r;
            end
            dbus_rsp.ack    = ($urandom_range(0, 9) < 3);
            dbus_rsp.r_data = $urandom;
            settle();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
